fsm_counter_ctrl: RTL and testbench

Job dispatcher that drives the run/count interface of an FSM counter worker from the issuing side. It queues count jobs from an upstream producer and issues each one to the worker with a one-cycle `o_run` pulse plus count value. It then waits for the worker's `i_done`, counts completions and flags a stuck worker through a watchdog. It sits between a job producer (CPU/regfile or test sequencer) and one counter worker.

---
 rtl/fsm_counter_pkg.sv | 15 +
 rtl/job_fifo.sv | 48 ++++
 rtl/fsm_counter_ctrl.sv | 105 ++++++++++
 tb/tb_fsm_counter_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_counter_pkg.sv
// Shared definitions for the counter job dispatcher: FSM encoding and
// default widths used by the top level and its FIFO.
package fsm_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_ERR   = 2'b11
  } state_t;

  localparam int CNT_W_DEF = 7;
  localparam int WDOG_W    = 8;

endpackage

// File: rtl/job_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued count jobs.
// Pointers carry a wrap bit so full and empty are distinguishable.
module job_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fsm_counter_ctrl.sv
// Dispatcher that queues count jobs and issues them one at a time to a
// counter worker, tracking completions and a watchdog for stuck workers.
module fsm_counter_ctrl
  import fsm_counter_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_job_valid,
  input  logic [CNT_W-1:0] i_job_num,
  output logic             o_job_ready,
  output logic             o_run,
  output logic [CNT_W-1:0] o_num_cnt,
  input  logic             i_idle,
  input  logic             i_done,
  input  logic             i_clear,
  output logic             o_busy,
  output logic             o_err_timeout,
  output logic [7:0]       o_jobs_done
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_num_cnt;
  logic [WDOG_W-1:0] r_wdog;
  logic [7:0]        r_jobs_done;

  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_head_zero;

  assign w_head_zero = (w_head == '0);
  assign o_job_ready = !w_full && (r_state != S_ERR);
  assign w_push      = i_job_valid && o_job_ready;
  // Zero-count jobs are discarded without waiting for the worker.
  assign w_pop       = (r_state == S_IDLE) && !w_empty && (w_head_zero || i_idle);
  assign w_flush     = (r_state == S_ERR) && i_clear;

  job_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (i_job_num),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_num_cnt   <= '0;
      r_wdog      <= '0;
      r_jobs_done <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop && !w_head_zero) begin
            r_num_cnt <= w_head;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wdog <= r_wdog + WDOG_W'(1);
          if (i_done)
            r_state <= S_IDLE;
          else if (r_wdog == WDOG_W'(TIMEOUT - 1))
            r_state <= S_ERR;
        end
        S_ERR: begin
          if (i_clear) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A clear always wins over a completion landing in the same cycle.
      if (i_clear)
        r_jobs_done <= '0;
      else if ((r_state == S_WAIT) && i_done)
        r_jobs_done <= r_jobs_done + 8'd1;
    end
  end

  assign o_run         = (r_state == S_ISSUE);
  assign o_num_cnt     = r_num_cnt;
  assign o_busy        = !w_empty || (r_state != S_IDLE);
  assign o_err_timeout = (r_state == S_ERR);
  assign o_jobs_done   = r_jobs_done;

endmodule

// File: tb/tb_fsm_counter_ctrl.sv
// Directed timing scenarios plus a randomized run scored against a job
// queue and completion count model, with a behavioural counter worker.
module tb_fsm_counter_ctrl;

  localparam int HIST = 2048;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_job_valid;
  logic [6:0] i_job_num;
  logic       o_job_ready;
  logic       o_run;
  logic [6:0] o_num_cnt;
  logic       i_idle;
  logic       i_done;
  logic       i_clear;
  logic       o_busy;
  logic       o_err_timeout;
  logic [7:0] o_jobs_done;

  fsm_counter_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .i_job_valid   (i_job_valid),
    .i_job_num     (i_job_num),
    .o_job_ready   (o_job_ready),
    .o_run         (o_run),
    .o_num_cnt     (o_num_cnt),
    .i_idle        (i_idle),
    .i_done        (i_done),
    .i_clear       (i_clear),
    .o_busy        (o_busy),
    .o_err_timeout (o_err_timeout),
    .o_jobs_done   (o_jobs_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural worker: loads N on a sampled run, pulses done N cycles later.
  logic wk_idle = 1'b1;
  logic wk_done = 1'b0;
  logic wk_busy = 1'b0;
  logic hang = 1'b0;
  logic hold_idle = 1'b0;
  int   extra = 0;
  int   rem = 0;
  assign i_idle = wk_idle && !hold_idle;
  assign i_done = wk_done;

  initial begin
    logic       pr;
    logic [6:0] pn;
    pr = 1'b0;
    pn = '0;
    forever begin
      @(posedge clk);
      #1;
      if (wk_done) begin
        wk_done = 1'b0;
        wk_idle = 1'b1;
      end
      if (wk_busy) begin
        rem--;
        if (rem == 0) begin
          wk_busy = 1'b0;
          wk_done = 1'b1;
        end
      end else if (pr && !hang) begin
        wk_busy = 1'b1;
        wk_idle = 1'b0;
        rem     = int'(pn) + extra;
      end
      pr = o_run;
      pn = o_num_cnt;
    end
  end

  // Monitor: histories are indexed by the edge that samples the value.
  logic       run_hist  [HIST];
  logic       busy_hist [HIST];
  logic       err_hist  [HIST];
  int         run_times[$];
  int         done_times[$];
  logic [6:0] run_vals[$];
  logic [6:0] exp_q[$];
  logic       sb_en = 1'b0;
  logic       outstanding = 1'b0;
  int         model_done = 0;

  initial begin
    logic prev_run;
    int   k;
    prev_run = 1'b0;
    forever begin
      @(negedge clk);
      k = cyc + 1;
      if (k < HIST) begin
        run_hist[k]  = o_run;
        busy_hist[k] = o_busy;
        err_hist[k]  = o_err_timeout;
      end
      if (o_run === 1'b1) begin
        run_times.push_back(k);
        run_vals.push_back(o_num_cnt);
        check("run_single_cycle", {31'd0, prev_run}, 0);
        if (sb_en) begin
          if (exp_q.size() == 0) check("sb_unexpected_run", 1, 0);
          else check("sb_run_num", {25'd0, o_num_cnt}, {25'd0, exp_q.pop_front()});
          outstanding = 1'b1;
        end
      end
      if (i_done) begin
        done_times.push_back(k);
        if (sb_en && outstanding) begin
          model_done++;
          outstanding = 1'b0;
        end
      end
      if (sb_en && i_job_valid && o_job_ready && (i_job_num != 0))
        exp_q.push_back(i_job_num);
      prev_run = o_run;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed cycle %0d expected finish", cyc);
    $fatal(1, "simulation time bound exceeded");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hist();
    run_times.delete();
    run_vals.delete();
    done_times.delete();
  endtask

  initial begin
    int t, e, a, u, exp_t, waited;
    int jobs2 [4];
    jobs2 = '{3, 1, 7, 2};
    reset = 1'b1;
    i_job_valid = 1'b0;
    i_job_num = '0;
    i_clear = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_run", {31'd0, o_run}, 0);
    check("rst_num_cnt", {25'd0, o_num_cnt}, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_err", {31'd0, o_err_timeout}, 0);
    check("rst_jobs_done", {24'd0, o_jobs_done}, 0);
    check("rst_ready", {31'd0, o_job_ready}, 1);
    reset = 1'b0;

    // Single job of 5
    clear_hist();
    i_job_valid = 1'b1; i_job_num = 7'd5;
    step(); t = cyc;
    i_job_valid = 1'b0;
    repeat (14) step();
    check("t1_run_count", run_times.size(), 1);
    check("t1_run_time", run_times.size() > 0 ? run_times[0] : -1, t + 2);
    check("t1_run_num", run_vals.size() > 0 ? {25'd0, run_vals[0]} : 32'hffff, 5);
    check("t1_run_width", {31'd0, run_hist[t + 3]}, 0);
    check("t1_done_time", done_times.size() > 0 ? done_times[0] : -1, t + 8);
    check("t1_busy_before", {31'd0, busy_hist[t + 8]}, 1);
    check("t1_busy_low", {31'd0, busy_hist[t + 9]}, 0);
    check("t1_jobs_done", {24'd0, o_jobs_done}, 1);

    // Fill FIFO with worker held non-idle, then release
    i_clear = 1'b1; step(); i_clear = 1'b0;
    check("t2_clear_jobs", {24'd0, o_jobs_done}, 0);
    clear_hist();
    hold_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_job_valid = 1'b1; i_job_num = 7'(jobs2[i]);
      step();
    end
    i_job_valid = 1'b0;
    check("t2_ready_full", {31'd0, o_job_ready}, 0);
    repeat (3) step();
    check("t2_no_run_held", run_times.size(), 0);
    e = cyc;
    hold_idle = 1'b0;
    repeat (40) step();
    check("t2_run_count", run_times.size(), 4);
    exp_t = e + 2;
    for (int i = 0; i < 4; i++) begin
      if (i < run_times.size()) begin
        check("t2_run_time", run_times[i], exp_t);
        check("t2_run_num", {25'd0, run_vals[i]}, jobs2[i]);
      end
      exp_t = exp_t + jobs2[i] + 3;
    end
    check("t2_jobs_done", {24'd0, o_jobs_done}, 4);
    check("t2_ready_back", {31'd0, o_job_ready}, 1);

    // Zero job dropped, next job dispatched
    i_clear = 1'b1; step(); i_clear = 1'b0;
    clear_hist();
    i_job_valid = 1'b1; i_job_num = 7'd0;
    step(); a = cyc;
    i_job_num = 7'd4;
    step();
    i_job_valid = 1'b0;
    repeat (12) step();
    check("t3_run_count", run_times.size(), 1);
    check("t3_no_run_zero", {31'd0, run_hist[a + 2]}, 0);
    check("t3_run_time", run_times.size() > 0 ? run_times[0] : -1, a + 3);
    check("t3_run_num", run_vals.size() > 0 ? {25'd0, run_vals[0]} : 32'hffff, 4);
    check("t3_jobs_done", {24'd0, o_jobs_done}, 1);

    // Stuck worker: watchdog, then clear flushes queued jobs
    clear_hist();
    hang = 1'b1;
    i_job_valid = 1'b1; i_job_num = 7'd10;
    step(); t = cyc;
    i_job_valid = 1'b0;
    repeat (3) step();
    i_job_valid = 1'b1; i_job_num = 7'd6; step();
    i_job_num = 7'd9; step();
    i_job_valid = 1'b0;
    while (cyc < t + 205) step();
    check("t4_err_before", {31'd0, err_hist[t + 202]}, 0);
    check("t4_err_at", {31'd0, err_hist[t + 203]}, 1);
    check("t4_err_sticky", {31'd0, o_err_timeout}, 1);
    check("t4_ready_err", {31'd0, o_job_ready}, 0);
    check("t4_busy_err", {31'd0, o_busy}, 1);
    i_clear = 1'b1; step(); i_clear = 1'b0;
    check("t4_err_cleared", {31'd0, o_err_timeout}, 0);
    check("t4_jobs_cleared", {24'd0, o_jobs_done}, 0);
    check("t4_fifo_flushed", {31'd0, o_busy}, 0);
    check("t4_ready_after", {31'd0, o_job_ready}, 1);
    hang = 1'b0;
    repeat (6) step();
    check("t4_no_dispatch", run_times.size(), 1);

    // Reset during S_WAIT with two jobs queued
    clear_hist();
    i_job_valid = 1'b1; i_job_num = 7'd2; step();
    i_job_valid = 1'b0;
    repeat (10) step();
    check("t6_pre_jobs", {24'd0, o_jobs_done}, 1);
    i_job_valid = 1'b1; i_job_num = 7'd20; step(); u = cyc;
    i_job_num = 7'd3; step();
    i_job_num = 7'd5; step();
    i_job_valid = 1'b0;
    while (cyc < u + 6) step();
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_run", {31'd0, o_run}, 0);
    check("t6_num_cnt", {25'd0, o_num_cnt}, 0);
    check("t6_busy", {31'd0, o_busy}, 0);
    check("t6_err", {31'd0, o_err_timeout}, 0);
    check("t6_jobs", {24'd0, o_jobs_done}, 0);
    check("t6_ready", {31'd0, o_job_ready}, 1);
    repeat (25) step();
    check("t6_late_done_ignored", {24'd0, o_jobs_done}, 0);
    check("t6_no_more_runs", run_times.size(), 2);
    check("t6_busy_after", {31'd0, o_busy}, 0);

    // Randomized traffic against the queue/completion model
    i_clear = 1'b1; step(); i_clear = 1'b0;
    exp_q.delete();
    model_done = 0;
    outstanding = 1'b0;
    sb_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      i_job_valid = 1'($urandom_range(0, 1));
      i_job_num   = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 15));
      hold_idle   = ($urandom_range(0, 9) == 0);
      extra       = int'($urandom_range(0, 3));
      step();
    end
    i_job_valid = 1'b0;
    hold_idle = 1'b0;
    waited = 0;
    while ((o_busy || !wk_idle || wk_done) && waited < 600) begin
      step();
      waited++;
    end
    check("rnd_drain_bound", {31'd0, (waited < 600)}, 1);
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_jobs_done", {24'd0, o_jobs_done}, {24'd0, 8'(model_done)});
    check("rnd_busy_end", {31'd0, o_busy}, 0);
    check("rnd_no_err", {31'd0, o_err_timeout}, 0);
    sb_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
